requant_gain_bank: RTL and testbench

Double-buffered per-channel gain table answering the requantizer's channel-address output with the gain for that channel. Sits beside the requantizer: consumes its `addr` stream and returns `gain` one cycle later. The host writes a shadow bank and requests a swap, which takes effect atomically on the next spectrum boundary (`sync_in`), so a spectrum never mixes old and new gains.

---
 rtl/requant_pkg.sv | 21 ++
 rtl/gain_ram.sv | 34 +++
 rtl/requant_gain_bank.sv | 143 ++++++++++++++
 tb/tb_requant_gain_bank.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/requant_pkg.sv
// ----------------------------------------------------------------------------
// requant_pkg: widths, defaults and types shared by the requantizer and gains
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package requant_pkg;
  localparam int INPUT_WIDTH  = 18;
  localparam int OUTPUT_WIDTH = 8;
  localparam int GAIN_WIDTH   = INPUT_WIDTH - OUTPUT_WIDTH + 1;
  localparam int DEFAULT_GAIN = 1;

  typedef logic [GAIN_WIDTH-1:0] gain_t;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } gb_state_e;
endpackage

`default_nettype wire

// File: rtl/gain_ram.sv
// ----------------------------------------------------------------------------
// gain_ram: simple dual-port RAM, one write port, one registered read port
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module gain_ram #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 11,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  // No reset so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/requant_gain_bank.sv
// ----------------------------------------------------------------------------
// requant_gain_bank: double-buffered per-channel gain table, swap on sync_in
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module requant_gain_bank
  import requant_pkg::*;
#(
  parameter int CHANNELS     = 2048,
  parameter int GAIN_WIDTH   = requant_pkg::GAIN_WIDTH,
  parameter int ADDR_WIDTH   = $clog2(CHANNELS) + 1,
  parameter int DEFAULT_GAIN = requant_pkg::DEFAULT_GAIN
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        ce,
  input  logic                        sync_in,
  input  logic [ADDR_WIDTH-1:0]       addr,
  output logic [GAIN_WIDTH-1:0]       gain,
  input  logic                        wr_en,
  input  logic [$clog2(CHANNELS)-1:0] wr_addr,
  input  logic [GAIN_WIDTH-1:0]       wr_data,
  input  logic                        swap_req,
  output logic                        swap_pending,
  output logic                        active_bank,
  output logic                        init_done,
  output logic                        wr_drop
);

  localparam int                    IW     = $clog2(CHANNELS);
  localparam logic [IW:0]           C_CH   = (IW+1)'(CHANNELS);
  localparam logic [IW-1:0]         C_LAST = IW'(CHANNELS - 1);
  localparam logic [GAIN_WIDTH-1:0] C_DEF  = GAIN_WIDTH'(DEFAULT_GAIN);

  gb_state_e             state_q;
  logic [IW-1:0]         init_cnt_q;
  logic                  active_q, pending_q, init_done_q, wr_drop_q;
  logic                  rd_vld_q, rd_init_q, rd_oor_q, rd_bank_q;

  logic [IW-1:0]         rd_idx;
  logic                  rd_oor, wr_oor, swap_take;
  logic [1:0]            ram_we;
  logic [IW-1:0]         ram_waddr;
  logic [GAIN_WIDTH-1:0] ram_wdata;
  logic [GAIN_WIDTH-1:0] ram_rdata [2];
  logic [ADDR_WIDTH-IW-1:0] unused_addr_hi;

  assign rd_idx         = addr[IW-1:0];
  assign unused_addr_hi = addr[ADDR_WIDTH-1:IW];
  assign rd_oor         = {1'b0, rd_idx} >= C_CH;
  assign wr_oor         = {1'b0, wr_addr} >= C_CH;
  assign swap_take      = ce && sync_in && (pending_q || swap_req);

  // INIT fills both banks; in RUN host writes target the bank not being read.
  always_comb begin
    ram_we    = 2'b00;
    ram_waddr = wr_addr;
    ram_wdata = wr_data;
    if (state_q == ST_INIT) begin
      ram_we    = 2'b11;
      ram_waddr = init_cnt_q;
      ram_wdata = C_DEF;
    end else if (wr_en && !wr_oor) begin
      ram_we = active_q ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_INIT;
      init_cnt_q  <= '0;
      active_q    <= 1'b0;
      pending_q   <= 1'b0;
      init_done_q <= 1'b0;
      wr_drop_q   <= 1'b0;
      rd_vld_q    <= 1'b0;
      rd_init_q   <= 1'b0;
      rd_oor_q    <= 1'b0;
      rd_bank_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_INIT: begin
          init_cnt_q <= init_cnt_q + IW'(1);
          wr_drop_q  <= wr_en || swap_req;
          if (init_cnt_q == C_LAST) begin
            state_q     <= ST_RUN;
            init_done_q <= 1'b1;
          end
        end
        ST_RUN: begin
          wr_drop_q <= wr_en && wr_oor;
          if (swap_take) begin
            active_q  <= ~active_q;
            pending_q <= 1'b0;
          end else if (swap_req) begin
            pending_q <= 1'b1;
          end
        end
        default: state_q <= ST_INIT;
      endcase
      // Bank select is latched with the read, so the sync-cycle read uses the old bank.
      if (ce) begin
        rd_vld_q  <= 1'b1;
        rd_init_q <= (state_q == ST_INIT);
        rd_oor_q  <= rd_oor;
        rd_bank_q <= active_q;
      end
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    gain_ram #(
      .DEPTH (CHANNELS),
      .WIDTH (GAIN_WIDTH),
      .AW    (IW)
    ) u_ram (
      .clk     (clk),
      .we_i    (ram_we[b]),
      .waddr_i (ram_waddr),
      .wdata_i (ram_wdata),
      .re_i    (ce),
      .raddr_i (rd_idx),
      .rdata_o (ram_rdata[b])
    );
  end

  always_comb begin
    gain = '0;
    if (rd_vld_q) begin
      if (rd_init_q)      gain = C_DEF;
      else if (!rd_oor_q) gain = rd_bank_q ? ram_rdata[1] : ram_rdata[0];
    end
  end

  assign swap_pending = pending_q;
  assign active_bank  = active_q;
  assign init_done    = init_done_q;
  assign wr_drop      = wr_drop_q;

endmodule

`default_nettype wire

// File: tb/tb_requant_gain_bank.sv
// ----------------------------------------------------------------------------
// tb_requant_gain_bank: directed scoreboard bench for requant_gain_bank (8 ch)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_requant_gain_bank;
  localparam int CH = 8;
  localparam int GW = 11;
  localparam int AW = 4;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          ce = 1'b0;
  logic          sync_in = 1'b0;
  logic [AW-1:0] addr = '0;
  logic [GW-1:0] gain;
  logic          wr_en = 1'b0;
  logic [IW-1:0] wr_addr = '0;
  logic [GW-1:0] wr_data = '0;
  logic          swap_req = 1'b0;
  logic          swap_pending, active_bank, init_done, wr_drop;

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  always #5 clk = ~clk;

  requant_gain_bank #(
    .CHANNELS     (CH),
    .GAIN_WIDTH   (GW),
    .ADDR_WIDTH   (AW),
    .DEFAULT_GAIN (1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .ce           (ce),
    .sync_in      (sync_in),
    .addr         (addr),
    .gain         (gain),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .swap_req     (swap_req),
    .swap_pending (swap_pending),
    .active_bank  (active_bank),
    .init_done    (init_done),
    .wr_drop      (wr_drop)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // One cycle of stimulus; a ce read queues its expected gain.
  task automatic step(input int c, input int s, input int a, input int we,
                      input int wa, input int wd, input int sr, input int e);
    @(negedge clk);
    ce       = (c != 0);
    sync_in  = (s != 0);
    addr     = AW'(a);
    wr_en    = (we != 0);
    wr_addr  = IW'(wa);
    wr_data  = GW'(wd);
    swap_req = (sr != 0);
    if (c != 0) exp_q.push_back(e);
  endtask

  task automatic rd(input int a, input int s, input int e);
    step(1, s, a, 0, 0, 0, 0, e);
  endtask

  task automatic settle;
    @(posedge clk);
    #2;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_gain"}, int'(gain), 0);
    chk({tag, "_active"}, int'(active_bank), 0);
    chk({tag, "_pending"}, int'(swap_pending), 0);
    chk({tag, "_init_done"}, int'(init_done), 0);
    chk({tag, "_wr_drop"}, int'(wr_drop), 0);
  endtask

  task automatic run_init(input string tag);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < CH; i++) begin
      step(1, 0, i, (i == 3) ? 1 : 0, 0, 0, (i == 5) ? 1 : 0, 1);
      settle();
      chk({tag, "_init_done"}, int'(init_done), (i == CH - 1) ? 1 : 0);
      chk({tag, "_wr_drop"}, int'(wr_drop), (i == 3 || i == 5) ? 1 : 0);
    end
    chk({tag, "_pending_after_init"}, int'(swap_pending), 0);
  endtask

  // Monitor: every ce edge must match the oldest queued expectation.
  initial begin
    forever begin
      @(posedge clk);
      if (ce && rst_n) begin
        #1;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL gain_unexpected: got %0d with no expected value queued", gain);
        end else begin
          int e;
          e = exp_q.pop_front();
          chk("gain", int'(gain), e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    #1;
    chk_reset_vals("reset");

    // INIT: writes and swap requests dropped, reads give default
    run_init("init");

    // RUN: all channels default, address MSB ignored
    for (int k = 0; k < CH; k++) rd(k + 8, (k == 0) ? 1 : 0, 1);

    // fill shadow bank 1 with 10+k; not visible yet
    for (int k = 0; k < CH; k++) step(0, 0, 0, 1, k, 10 + k, 0, 0);
    settle();
    chk("shadow_wr_no_drop", int'(wr_drop), 0);
    for (int sp = 0; sp < 2; sp++)
      for (int k = 0; k < CH; k++) rd(k, (k == 0) ? 1 : 0, 1);

    step(0, 0, 0, 0, 0, 0, 1, 0);
    settle();
    chk("pending_set", int'(swap_pending), 1);
    chk("active_before_swap", int'(active_bank), 0);
    step(0, 0, 0, 0, 0, 0, 1, 0);
    settle();
    chk("pending_repeat", int'(swap_pending), 1);

    rd(0, 1, 1);
    settle();
    chk("active_after_swap1", int'(active_bank), 1);
    chk("pending_clear1", int'(swap_pending), 0);
    for (int k = 1; k < CH; k++) rd(k, 0, 10 + k);
    for (int k = 0; k < CH; k++) rd(k, (k == 0) ? 1 : 0, 10 + k);

    // bank 0 becomes 20+k, swap requested on the sync cycle itself
    for (int k = 0; k < CH; k++) step(0, 0, 0, 1, k, 20 + k, 0, 0);
    step(1, 1, 0, 0, 0, 0, 1, 10);
    settle();
    chk("coincident_pending", int'(swap_pending), 0);
    chk("coincident_active", int'(active_bank), 0);
    rd(1, 0, 21);
    settle();
    chk("coincident_pending_later", int'(swap_pending), 0);
    for (int k = 2; k < CH; k++) rd(k, 0, 20 + k);

    // ce stall mid-spectrum; sync without ce must not swap
    rd(0, 1, 20);
    rd(1, 0, 21);
    rd(2, 0, 22);
    for (int j = 0; j < 3; j++) begin
      step(0, (j == 1) ? 1 : 0, 5, 0, 0, 0, (j == 0) ? 1 : 0, 0);
      settle();
      chk("gain_hold", int'(gain), 22);
    end
    chk("nosync_pending", int'(swap_pending), 1);
    chk("nosync_active", int'(active_bank), 0);
    for (int k = 3; k < CH; k++) rd(k, 0, 20 + k);

    // swap taken with a coincident write to channel 2 of the pre-swap shadow
    step(1, 1, 0, 1, 2, 99, 0, 20);
    settle();
    chk("active_after_swap3", int'(active_bank), 1);
    chk("pending_clear3", int'(swap_pending), 0);
    chk("swap_wr_no_drop", int'(wr_drop), 0);
    for (int k = 1; k < CH; k++) rd(k, 0, (k == 2) ? 99 : 10 + k);

    // reset while a swap is pending
    step(0, 0, 0, 0, 0, 0, 1, 0);
    settle();
    chk("pending_before_reset", int'(swap_pending), 1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midreset");
    run_init("reinit");
    step(0, 0, 0, 0, 0, 0, 1, 0);
    rd(0, 1, 1);
    settle();
    chk("active_after_reinit_swap", int'(active_bank), 1);
    for (int k = 1; k < CH; k++) rd(k, 0, 1);

    step(0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    chk("queue_drained", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
